// File: rtl/router_fsm.sv
// router_fsm: packet router control FSM.
// Steers header decode, first-byte/data/parity loading, FIFO-full stalls
// and waiting for the destination FIFO to drain.
// Optional feature: define ROUTER_FSM_WDOG_EN to add a WAIT_TILL_EMPTY
// watchdog that gives up after 63 cycles and pulses wdog_timeout.
// Outputs are flops loaded from the decode of the next state. Their timing
// therefore matches a decode of the state register, and no input reaches
// an output without passing through a flop.
module router_fsm (
    input  logic       clock,
    input  logic       rstn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic [1:0] addr_q,
    output logic       wdog_timeout
);

    localparam int unsigned ADDR_W = 2;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t state_q;
    state_t state_d;

    logic empty_hdr;   // empty flag of the FIFO named by the incoming header
    logic empty_sel;   // empty flag of the latched destination FIFO
    logic soft_sel;    // soft reset of the latched destination FIFO
    logic hdr_ok;      // header names a real FIFO (0..2)

    logic detect_d;
    logic lfd_d;
    logic ld_d;
    logic laf_d;
    logic full_d;
    logic rst_int_d;
    logic wen_d;
    logic busy_d;

`ifdef ROUTER_FSM_WDOG_EN
    localparam int unsigned WDOG_W   = 6;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(63);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_fire;
`endif

    // Per-FIFO flag selection by header address and by latched address
    always_comb begin
        empty_hdr = 1'b0;
        empty_sel = 1'b0;
        soft_sel  = 1'b0;
        hdr_ok    = (data_in != ADDR_W'(3));
        case (data_in)
            2'd0:    empty_hdr = fifo_empty_0;
            2'd1:    empty_hdr = fifo_empty_1;
            2'd2:    empty_hdr = fifo_empty_2;
            default: empty_hdr = 1'b0;
        endcase
        case (addr_q)
            2'd0: begin
                empty_sel = fifo_empty_0;
                soft_sel  = soft_reset_0;
            end
            2'd1: begin
                empty_sel = fifo_empty_1;
                soft_sel  = soft_reset_1;
            end
            2'd2: begin
                empty_sel = fifo_empty_2;
                soft_sel  = soft_reset_2;
            end
            default: begin
                empty_sel = 1'b0;
                soft_sel  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q <= DECODE_ADDRESS;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and decode of the next state for the output flops
    always_comb begin
        state_d   = state_q;
`ifdef ROUTER_FSM_WDOG_EN
        wdog_fire = 1'b0;
`endif
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid && hdr_ok) begin
                    state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full) begin
                    state_d = FIFO_FULL_STATE;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) begin
                    state_d = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (parity_done) begin
                    state_d = DECODE_ADDRESS;
                end else if (low_pkt_valid) begin
                    state_d = LOAD_PARITY;
                end else begin
                    state_d = LOAD_DATA;
                end
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel) begin
                    state_d = LOAD_FIRST_DATA;
                end
`ifdef ROUTER_FSM_WDOG_EN
                else if (wdog_cnt_q == WDOG_MAX) begin
                    state_d   = DECODE_ADDRESS;
                    wdog_fire = 1'b1;
                end
`endif
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A soft reset of the selected FIFO abandons the packet from any state
        if (soft_sel) begin
            state_d   = DECODE_ADDRESS;
`ifdef ROUTER_FSM_WDOG_EN
            wdog_fire = 1'b0;
`endif
        end

        detect_d  = (state_d == DECODE_ADDRESS);
        lfd_d     = (state_d == LOAD_FIRST_DATA);
        ld_d      = (state_d == LOAD_DATA);
        full_d    = (state_d == FIFO_FULL_STATE);
        laf_d     = (state_d == LOAD_AFTER_FULL);
        rst_int_d = (state_d == CHECK_PARITY_ERROR);
        wen_d     = (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                    (state_d == LOAD_AFTER_FULL);
        busy_d    = (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
    end

    // State-decode output flops
    always_ff @(posedge clock) begin
        if (!rstn) begin
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            full_state    <= 1'b0;
            laf_state     <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
        end else begin
            detect_add    <= detect_d;
            lfd_state     <= lfd_d;
            ld_state      <= ld_d;
            full_state    <= full_d;
            laf_state     <= laf_d;
            rst_int_reg   <= rst_int_d;
            write_enb_reg <= wen_d;
            busy          <= busy_d;
        end
    end

    // Destination address latch, loaded from a valid header
    always_ff @(posedge clock) begin
        if (!rstn) begin
            addr_q <= '0;
        end else if ((state_q == DECODE_ADDRESS) && pkt_valid && hdr_ok) begin
            addr_q <= data_in;
        end
    end

`ifdef ROUTER_FSM_WDOG_EN
    // Watchdog: clears on entry to WAIT_TILL_EMPTY, counts and saturates there
    always_ff @(posedge clock) begin
        if (!rstn) begin
            wdog_cnt_q <= '0;
        end else if ((state_d == WAIT_TILL_EMPTY) && (state_q != WAIT_TILL_EMPTY)) begin
            wdog_cnt_q <= '0;
        end else if ((state_q == WAIT_TILL_EMPTY) && (wdog_cnt_q != WDOG_MAX)) begin
            wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
        end
    end

    // One-cycle timeout pulse aligned with the return to DECODE_ADDRESS
    always_ff @(posedge clock) begin
        if (!rstn) begin
            wdog_timeout <= 1'b0;
        end else begin
            wdog_timeout <= wdog_fire;
        end
    end
`else
    assign wdog_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm. Output decodes are checked as one 8-bit
// vector {detect_add, lfd, ld, full, laf, rst_int, write_enb, busy}.
module tb_router_fsm;

    localparam logic [7:0] O_DA   = 8'h80;
    localparam logic [7:0] O_LFD  = 8'h41;
    localparam logic [7:0] O_LD   = 8'h22;
    localparam logic [7:0] O_FULL = 8'h11;
    localparam logic [7:0] O_LAF  = 8'h0B;
    localparam logic [7:0] O_LP   = 8'h03;
    localparam logic [7:0] O_CPE  = 8'h05;
    localparam logic [7:0] O_WTE  = 8'h01;

    logic       clock = 1'b0;
    logic       rstn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy, wdog_timeout;
    logic [1:0] addr_q;

    int checks   = 0;
    int failures = 0;

    router_fsm dut (
        .clock         (clock),
        .rstn          (rstn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy),
        .addr_q        (addr_q),
        .wdog_timeout  (wdog_timeout)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] outs();
        return {detect_add, lfd_state, ld_state, full_state, laf_state,
                rst_int_reg, write_enb_reg, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rstn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_pkt_valid = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_outs", 32'(outs()), 32'(O_DA));
        check("rst_addr", 32'(addr_q), 0);
        check("rst_wdog", 32'(wdog_timeout), 0);
        rstn = 1'b1;
        tick();
        check("post_rst_outs", 32'(outs()), 32'(O_DA));

        // Packet to FIFO 1, normal end through parity
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(); check("p1_lfd", 32'(outs()), 32'(O_LFD));
        check("p1_addr", 32'(addr_q), 1);
        data_in = 2'd3;
        tick(); check("p1_ld", 32'(outs()), 32'(O_LD));
        tick(); check("p1_ld_hold", 32'(outs()), 32'(O_LD));
        check("p1_addr_hold", 32'(addr_q), 1);
        pkt_valid = 1'b0;
        tick(); check("p1_lp", 32'(outs()), 32'(O_LP));
        tick(); check("p1_cpe", 32'(outs()), 32'(O_CPE));
        tick(); check("p1_da", 32'(outs()), 32'(O_DA));

        // Packet to FIFO 0 with a 3-cycle full stall then low_pkt_valid
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(); check("p2_lfd", 32'(outs()), 32'(O_LFD));
        check("p2_addr", 32'(addr_q), 0);
        tick(); check("p2_ld", 32'(outs()), 32'(O_LD));
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("p2_full", 32'(outs()), 32'(O_FULL));
        end
        fifo_full = 1'b0;
        tick(); check("p2_laf", 32'(outs()), 32'(O_LAF));
        low_pkt_valid = 1'b1; pkt_valid = 1'b0;
        tick(); check("p2_lp", 32'(outs()), 32'(O_LP));
        low_pkt_valid = 1'b0; fifo_full = 1'b1;
        tick(); check("p2_cpe", 32'(outs()), 32'(O_CPE));
        tick(); check("p2_cpe_full", 32'(outs()), 32'(O_FULL));
        fifo_full = 1'b0;
        tick(); check("p2_laf2", 32'(outs()), 32'(O_LAF));
        pkt_valid = 1'b1;
        tick(); check("p2_laf_ld", 32'(outs()), 32'(O_LD));
        fifo_full = 1'b1;
        tick(); check("p2_full2", 32'(outs()), 32'(O_FULL));
        fifo_full = 1'b0;
        tick(); check("p2_laf3", 32'(outs()), 32'(O_LAF));
        parity_done = 1'b1; pkt_valid = 1'b0;
        tick(); check("p2_pdone_da", 32'(outs()), 32'(O_DA));
        parity_done = 1'b0;

        // FIFO 2 busy: wait, then drain, then soft reset of FIFO 2
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        tick(); check("p3_wte", 32'(outs()), 32'(O_WTE));
        check("p3_addr", 32'(addr_q), 2);
        data_in = 2'd0;
        tick(); check("p3_wte_hold", 32'(outs()), 32'(O_WTE));
        fifo_empty_2 = 1'b1;
        tick(); check("p3_lfd", 32'(outs()), 32'(O_LFD));
        soft_reset_2 = 1'b1;
        tick(); check("p3_srst_da", 32'(outs()), 32'(O_DA));
        soft_reset_2 = 1'b0; pkt_valid = 1'b0;
        check("p3_addr_keep", 32'(addr_q), 2);
        tick();

        // Soft reset filtering: only the selected FIFO's soft reset counts
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(); check("p4_lfd", 32'(outs()), 32'(O_LFD));
        tick(); check("p4_ld", 32'(outs()), 32'(O_LD));
        soft_reset_1 = 1'b1;
        tick(); check("p4_srst1_ignored", 32'(outs()), 32'(O_LD));
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick(); check("p4_srst0_da", 32'(outs()), 32'(O_DA));
        soft_reset_0 = 1'b0; data_in = 2'd3;
        tick(); check("p4_addr3_stay", 32'(outs()), 32'(O_DA));
        check("p4_addr3_keep", 32'(addr_q), 0);

        // rstn mid-packet abandons the packet
        data_in = 2'd1;
        tick(); check("p5_lfd", 32'(outs()), 32'(O_LFD));
        tick(); check("p5_ld", 32'(outs()), 32'(O_LD));
        rstn = 1'b0; soft_reset_1 = 1'b1;
        tick(); check("p5_rst_outs", 32'(outs()), 32'(O_DA));
        check("p5_rst_addr", 32'(addr_q), 0);
        rstn = 1'b1; soft_reset_1 = 1'b0; pkt_valid = 1'b0;
        tick(); check("p5_no_wen", 32'(write_enb_reg), 0);

        // Waiting on FIFO 0 that never drains
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
        tick(); check("p6_wte", 32'(outs()), 32'(O_WTE));
        pkt_valid = 1'b0;
`ifdef ROUTER_FSM_WDOG_EN
        for (int i = 1; i <= 63; i++) begin
            tick();
            check("p6_wte_wait", 32'({outs(), wdog_timeout}), 32'({O_WTE, 1'b0}));
        end
        tick();
        check("p6_wdog_da", 32'(outs()), 32'(O_DA));
        check("p6_wdog_pulse", 32'(wdog_timeout), 1);
        tick();
        check("p6_wdog_clear", 32'(wdog_timeout), 0);
        check("p6_da_stay", 32'(outs()), 32'(O_DA));
`else
        for (int i = 1; i <= 200; i++) begin
            tick();
        end
        check("p6_still_wte", 32'(outs()), 32'(O_WTE));
        check("p6_no_wdog", 32'(wdog_timeout), 0);
        soft_reset_0 = 1'b1;
        tick(); check("p6_srst_da", 32'(outs()), 32'(O_DA));
        soft_reset_0 = 1'b0;
`endif
        fifo_empty_0 = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have a single clock and a synchronous, active-low reset: `clock` samples every flop on its rising edge; `rstn`=0 resets on that edge.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- `clock` in 1: system clock.
- `rstn` in 1: synchronous active-low reset.
- `pkt_valid` in 1: source is driving packet bytes.
- `data_in` in 2: header address bits [1:0].
- `fifo_full` in 1: full flag of the currently selected output FIFO.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-FIFO soft reset, active high.
- `parity_done` in 1: parity byte has been captured.
- `low_pkt_valid` in 1: pkt_valid fell while the FIFO was full.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` out 1 each: state decodes.
- `write_enb_reg` out 1: FIFO write permission.
- `busy` out 1: source must hold its data.
- `addr_q` out 2: latched destination address.
- `wdog_timeout` out 1: watchdog fired.

Function
REQ-003 SHALL implement a Moore FSM with 8 states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-004 SHALL load `addr_q` <= `data_in` in DECODE_ADDRESS when `pkt_valid`=1 and `data_in`!=3, and hold `addr_q` in all other cases.
REQ-005 SHALL leave DECODE_ADDRESS as follows: `pkt_valid` and `data_in`=n (n in 0..2) with `fifo_empty_n`=1 -> LOAD_FIRST_DATA; with `fifo_empty_n`=0 -> WAIT_TILL_EMPTY; otherwise, including `data_in`=3, it stays.
REQ-006 SHALL go LOAD_FIRST_DATA -> LOAD_DATA unconditionally after one cycle.
REQ-007 SHALL leave LOAD_DATA as follows: `fifo_full` -> FIFO_FULL_STATE; else `pkt_valid`=0 -> LOAD_PARITY; else it stays. `fifo_full` has priority.
REQ-008 SHALL go FIFO_FULL_STATE -> LOAD_AFTER_FULL when `fifo_full`=0, and otherwise stay.
REQ-009 SHALL leave LOAD_AFTER_FULL as follows: `parity_done` -> DECODE_ADDRESS; else `low_pkt_valid` -> LOAD_PARITY; else -> LOAD_DATA.
REQ-010 SHALL go LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally after one cycle.
REQ-011 SHALL leave CHECK_PARITY_ERROR as follows: `fifo_full` -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-012 SHALL go WAIT_TILL_EMPTY -> LOAD_FIRST_DATA when `fifo_empty_[addr_q]`=1, and otherwise stay.
REQ-013 SHALL force next state DECODE_ADDRESS from any state when `soft_reset_[addr_q]`=1; this overrides REQ-005..012. Soft resets of non-selected FIFOs SHALL be ignored.
REQ-014 SHALL decode the outputs combinationally from the registered state only:
- `detect_add` = DECODE_ADDRESS
- `lfd_state` = LOAD_FIRST_DATA
- `ld_state` = LOAD_DATA
- `full_state` = FIFO_FULL_STATE
- `laf_state` = LOAD_AFTER_FULL
- `rst_int_reg` = CHECK_PARITY_ERROR
REQ-015 SHALL drive `write_enb_reg`=1 exactly in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
REQ-016 SHALL drive `busy`=1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-017 SHALL make every output change exactly one clock after the qualifying inputs are sampled; there is no combinational input-to-output path.

Reset
REQ-018 SHALL on `rstn`=0 set state=DECODE_ADDRESS, `addr_q`=0 and the watchdog counter=0.
REQ-019 SHALL hold these output values during and immediately after reset: `detect_add`=1, all other 1-bit outputs 0, `addr_q`=0.
REQ-020 SHALL abandon any in-flight packet when `rstn` is asserted mid-packet; no further `write_enb_reg` pulses occur.
REQ-021 SHALL give `rstn` priority over soft resets and over the watchdog.

Configuration
REQ-022 SHALL compile the WAIT_TILL_EMPTY watchdog in only when macro `ROUTER_FSM_WDOG_EN` is defined. When defined:
- a 6-bit counter clears on entry to WAIT_TILL_EMPTY and increments each cycle spent there;
- if the counter reaches 63 with `fifo_empty_[addr_q]` still 0, next state is DECODE_ADDRESS and `wdog_timeout` pulses 1 for one cycle;
- the counter saturates and does not wrap.
REQ-023 SHALL, without `ROUTER_FSM_WDOG_EN`, wait indefinitely in WAIT_TILL_EMPTY, tie `wdog_timeout` to 0, and contain no counter.

Verification
REQ-024 SHALL be covered by these directed scenarios:
- Reset, then `pkt_valid`=1, `data_in`=1, `fifo_empty_1`=1 -> `lfd_state`=1 next cycle, then `ld_state`=1, `addr_q`=1.
- In LOAD_DATA drop `pkt_valid` -> LOAD_PARITY (`write_enb_reg`=1, `busy`=1), then CHECK_PARITY_ERROR (`rst_int_reg`=1), then DECODE_ADDRESS.
- Assert `fifo_full` in LOAD_DATA for 3 cycles -> `full_state`=1 for 3 cycles with `write_enb_reg`=0; then `laf_state`=1. With `low_pkt_valid`=1 -> LOAD_PARITY.
- `data_in`=2 with `fifo_empty_2`=0 -> WAIT_TILL_EMPTY (`busy`=1); raise `fifo_empty_2` -> LOAD_FIRST_DATA next cycle.
- Mid-packet to FIFO 0: `soft_reset_1`=1 -> no effect; `soft_reset_0`=1 -> `detect_add`=1 next cycle. `data_in`=3 -> stays in DECODE_ADDRESS.
- With `ROUTER_FSM_WDOG_EN` defined: `fifo_empty_0` held 0 in WAIT_TILL_EMPTY -> `wdog_timeout` pulses after 63 cycles and the FSM returns to DECODE_ADDRESS. Without the macro: still waiting after 200 cycles.
